// File: rtl/snoopy_key_lock_ctrl_if.sv
// Requester-side lock handshake bundle for snoopy_key_lock_ctrl.
// Latency: none (wires only).
// Backpressure: a requester holds lock_req, lock_op and lock_key until it sees its ack or nack pulse.
//
// Signals:
//   lock_req   per-requester request
//   lock_op    per-requester op (0 = lock, 1 = unlock)
//   lock_key   requester i key at [i*KEY_W +: KEY_W]
//   lock_ack   one-cycle pulse, op completed
//   lock_nack  one-cycle pulse, op refused
// Modports: master = requester side, slave = lock controller side.
interface snoopy_key_lock_ctrl_if #(
  parameter int NUM_REQ = 4,
  parameter int KEY_W   = 32
);
  logic [NUM_REQ-1:0]       lock_req;
  logic [NUM_REQ-1:0]       lock_op;
  logic [NUM_REQ*KEY_W-1:0] lock_key;
  logic [NUM_REQ-1:0]       lock_ack;
  logic [NUM_REQ-1:0]       lock_nack;

  modport master (
    output lock_req,
    output lock_op,
    output lock_key,
    input  lock_ack,
    input  lock_nack
  );

  modport slave (
    input  lock_req,
    input  lock_op,
    input  lock_key,
    output lock_ack,
    output lock_nack
  );
endinterface

// File: rtl/snoopy_key_lock_ctrl.sv
// Central key-lock manager: round-robin picks one lock/unlock request and checks it against a small CAM lock table.
// Latency: request sampled in IDLE at cycle T -> ack/nack pulse in T+2; locked_count/table_full/stats update in T+3; 1 op per 4 cycles.
// Backpressure: unserved requesters simply keep lock_req high and wait; nothing is dropped while the request is held.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset (aborts any op, clears the table)
//   bus (slave)     lock_req/lock_op/lock_key in, lock_ack/lock_nack out (see snoopy_key_lock_ctrl_if)
//   locked_count    number of valid table entries
//   table_full      locked_count == NUM_ENTRIES
//   stat_grants     saturating count of lock acks
//   stat_conflicts  saturating count of lock nacks
// Optional feature macro: SNOOPY_LOCK_STATS_EN builds the statistics counters;
// without it stat_grants and stat_conflicts are tied to zero.
module snoopy_key_lock_ctrl #(
  parameter int NUM_REQ     = 4,
  parameter int KEY_W       = 32,
  parameter int NUM_ENTRIES = 8,
  localparam int IW = $clog2(NUM_REQ),
  localparam int EW = $clog2(NUM_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   reset,
  snoopy_key_lock_ctrl_if.slave  bus,
  output logic [EW:0]            locked_count,
  output logic                   table_full,
  output logic [31:0]            stat_grants,
  output logic [31:0]            stat_conflicts
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOOKUP   = 2'd1,
    RESPOND  = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Latched request
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    cur;
  logic             cur_op;
  logic [KEY_W-1:0] cur_key;

  // Lock table
  logic                ent_vld   [NUM_ENTRIES];
  logic [KEY_W-1:0]    ent_key   [NUM_ENTRIES];
  logic [IW-1:0]       ent_owner [NUM_ENTRIES];

  // Registered lookup results (valid during RESPOND)
  logic                hit;
  logic [EW-1:0]       hit_idx;
  logic [IW-1:0]       hit_owner;
  logic                free_vld;
  logic [EW-1:0]       free_idx;

  // Response pulses
  logic [NUM_REQ-1:0]  ack_q;
  logic [NUM_REQ-1:0]  nack_q;

  // Combinational arbiter
  logic                arb_vld;
  logic [IW-1:0]       arb_idx;

  // Combinational lookup
  logic                lk_hit;
  logic [EW-1:0]       lk_hit_idx;
  logic [IW-1:0]       lk_hit_owner;
  logic                lk_free_vld;
  logic [EW-1:0]       lk_free_idx;
  logic                lk_ok;
  logic                resp_ok;

  // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int j;
    j       = 0;
    arb_vld = 1'b0;
    arb_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!arb_vld && bus.lock_req[j]) begin
        arb_vld = 1'b1;
        arb_idx = IW'(j);
      end
    end
  end

  // CAM compare against the latched key. At most one entry can match,
  // since a lock is only installed after a miss. The free search runs
  // downward so the lowest invalid index wins.
  always_comb begin
    lk_hit       = 1'b0;
    lk_hit_idx   = '0;
    lk_hit_owner = '0;
    lk_free_vld  = 1'b0;
    lk_free_idx  = '0;
    for (int e = NUM_ENTRIES - 1; e >= 0; e--) begin
      if (!ent_vld[e]) begin
        lk_free_vld = 1'b1;
        lk_free_idx = EW'(e);
      end
    end
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      if (ent_vld[e] && (ent_key[e] == cur_key)) begin
        lk_hit       = 1'b1;
        lk_hit_idx   = EW'(e);
        lk_hit_owner = ent_owner[e];
      end
    end
  end

  // Decision from live lookup feeds the response flops; the same decision
  // is rebuilt from the registered lookup to drive the table update.
  // Locks are not reentrant: any hit refuses a lock, even by the owner.
  assign lk_ok   = cur_op ? (lk_hit && (lk_hit_owner == cur)) : (!lk_hit && lk_free_vld);
  assign resp_ok = cur_op ? (hit && (hit_owner == cur))       : (!hit && free_vld);

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (arb_vld) state_nxt = LOOKUP;
      LOOKUP:   state_nxt = RESPOND;
      RESPOND:  state_nxt = COOLDOWN;
      COOLDOWN: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Request latch, lookup registers, response pulses and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= '0;
      cur       <= '0;
      cur_op    <= 1'b0;
      cur_key   <= '0;
      hit       <= 1'b0;
      hit_idx   <= '0;
      hit_owner <= '0;
      free_vld  <= 1'b0;
      free_idx  <= '0;
      ack_q     <= '0;
      nack_q    <= '0;
    end else begin
      ack_q  <= '0;
      nack_q <= '0;
      case (state)
        IDLE: begin
          if (arb_vld) begin
            cur     <= arb_idx;
            cur_op  <= bus.lock_op[arb_idx];
            cur_key <= bus.lock_key[int'(arb_idx)*KEY_W +: KEY_W];
          end
        end
        LOOKUP: begin
          hit         <= lk_hit;
          hit_idx     <= lk_hit_idx;
          hit_owner   <= lk_hit_owner;
          free_vld    <= lk_free_vld;
          free_idx    <= lk_free_idx;
          ack_q[cur]  <= lk_ok;
          nack_q[cur] <= !lk_ok;
        end
        RESPOND: begin
          rr_ptr <= (cur == IW'(NUM_REQ - 1)) ? '0 : cur + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Table and occupancy count; both change at the end of RESPOND.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        ent_vld[e]   <= 1'b0;
        ent_key[e]   <= '0;
        ent_owner[e] <= '0;
      end
      locked_count <= '0;
    end else if ((state == RESPOND) && resp_ok) begin
      if (!cur_op) begin
        ent_vld[free_idx]   <= 1'b1;
        ent_key[free_idx]   <= cur_key;
        ent_owner[free_idx] <= cur;
        locked_count        <= locked_count + 1'b1;
      end else begin
        ent_vld[hit_idx]    <= 1'b0;
        locked_count        <= locked_count - 1'b1;
      end
    end
  end

  assign table_full    = (locked_count == (EW+1)'(NUM_ENTRIES));
  assign bus.lock_ack  = ack_q;
  assign bus.lock_nack = nack_q;

`ifdef SNOOPY_LOCK_STATS_EN
  // Only lock results are counted; unlock outcomes are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_grants    <= '0;
      stat_conflicts <= '0;
    end else if ((state == RESPOND) && !cur_op) begin
      if (resp_ok) begin
        if (stat_grants != 32'hFFFF_FFFF) stat_grants <= stat_grants + 32'd1;
      end else begin
        if (stat_conflicts != 32'hFFFF_FFFF) stat_conflicts <= stat_conflicts + 32'd1;
      end
    end
  end
`else
  assign stat_grants    = 32'd0;
  assign stat_conflicts = 32'd0;
`endif

endmodule

// File: tb/tb_snoopy_key_lock_ctrl.sv
// Directed bench for snoopy_key_lock_ctrl: lock/unlock outcomes, latency, round-robin order,
// full-table handling and mid-op reset, with hand-computed expectations.
module tb_snoopy_key_lock_ctrl;
  localparam int NUM_REQ     = 4;
  localparam int KEY_W       = 32;
  localparam int NUM_ENTRIES = 8;

  logic        clk;
  logic        reset;
  logic [3:0]  locked_count;
  logic        table_full;
  logic [31:0] stat_grants;
  logic [31:0] stat_conflicts;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_grants = 0;
  int exp_conf   = 0;

  snoopy_key_lock_ctrl_if #(.NUM_REQ(NUM_REQ), .KEY_W(KEY_W)) bus ();

  snoopy_key_lock_ctrl #(
    .NUM_REQ(NUM_REQ), .KEY_W(KEY_W), .NUM_ENTRIES(NUM_ENTRIES)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .locked_count   (locked_count),
    .table_full     (table_full),
    .stat_grants    (stat_grants),
    .stat_conflicts (stat_conflicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stats(input string tag);
`ifdef SNOOPY_LOCK_STATS_EN
    check({tag, "_grants"}, stat_grants, exp_grants);
    check({tag, "_conf"}, stat_conflicts, exp_conf);
`else
    check({tag, "_grants"}, stat_grants, 0);
    check({tag, "_conf"}, stat_conflicts, 0);
`endif
  endtask

  // Issue one op from an idle controller, expect the pulse two cycles after
  // sampling, then walk through COOLDOWN back into IDLE.
  task automatic do_op(input int r, input logic op, input logic [31:0] key,
                       input logic exp_ok, input int exp_cnt, input string tag);
    int cyc;
    logic [3:0] a, n;
    bus.lock_op[r] = op;
    bus.lock_key[r*KEY_W +: KEY_W] = key;
    bus.lock_req[r] = 1'b1;
    cyc = 0; a = '0; n = '0;
    while (cyc < 20 && a == 0 && n == 0) begin
      step();
      cyc++;
      a = bus.lock_ack;
      n = bus.lock_nack;
    end
    check({tag, "_lat"}, cyc, 2);
    check({tag, "_ack"}, a, exp_ok ? (4'b1 << r) : 4'b0);
    check({tag, "_nack"}, n, exp_ok ? 4'b0 : (4'b1 << r));
    bus.lock_req[r] = 1'b0;
    if (!op) begin
      if (exp_ok) exp_grants++;
      else        exp_conf++;
    end
    step();
    check({tag, "_pulse"}, {bus.lock_ack, bus.lock_nack}, 8'h00);
    check({tag, "_cnt"}, locked_count, exp_cnt);
    check({tag, "_full"}, table_full, exp_cnt == NUM_ENTRIES);
    check_stats(tag);
    step();
  endtask

  initial begin
    int t [NUM_REQ];
    logic nack_seen;

    bus.lock_req = '0;
    bus.lock_op  = '0;
    bus.lock_key = '0;
    reset = 1'b1;
    step(); step();
    check("rst_ack", bus.lock_ack, 0);
    check("rst_nack", bus.lock_nack, 0);
    check("rst_cnt", locked_count, 0);
    check("rst_full", table_full, 0);
    check_stats("rst");
    reset = 1'b0;
    step();

    // Basic lock, conflict, wrong-owner unlock, owner unlock
    do_op(0, 1'b0, 32'h10, 1'b1, 1, "t1_lock");
    do_op(1, 1'b0, 32'h10, 1'b0, 1, "t2_conflict");
    do_op(1, 1'b1, 32'h10, 1'b0, 1, "t3_unlock_notowner");
    do_op(0, 1'b1, 32'h10, 1'b1, 0, "t3_unlock_owner");
    do_op(0, 1'b1, 32'h10, 1'b0, 0, "t3_unlock_miss");
    do_op(2, 1'b0, 32'h20, 1'b1, 1, "t3_lock20");
    do_op(2, 1'b0, 32'h20, 1'b0, 1, "t3_reentrant");
    do_op(2, 1'b1, 32'h20, 1'b1, 0, "t3_unlock20");

    // Round robin: all four requesters at once; rr_ptr is 0 after req2+1=3? no: last op was req2 -> rr_ptr=3
    // Bring rr_ptr back to 0 with one op from req3.
    do_op(3, 1'b1, 32'h99, 1'b0, 0, "t4_align");
    for (int r = 0; r < NUM_REQ; r++) begin
      bus.lock_op[r] = 1'b0;
      bus.lock_key[r*KEY_W +: KEY_W] = 32'(r + 1);
      t[r] = 0;
    end
    bus.lock_req = 4'hF;
    nack_seen = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      step();
      if (bus.lock_nack != 0) nack_seen = 1'b1;
      for (int r = 0; r < NUM_REQ; r++) begin
        if (bus.lock_ack[r] && t[r] == 0) begin
          t[r] = cyc;
          bus.lock_req[r] = 1'b0;
        end
      end
      if (bus.lock_req == 0) break;
    end
    bus.lock_req = '0;
    check("t4_nack", nack_seen, 0);
    check("t4_t0", t[0], 2);
    check("t4_t1", t[1], 6);
    check("t4_t2", t[2], 10);
    check("t4_t3", t[3], 14);
    exp_grants += 4;
    step();
    check("t4_cnt", locked_count, 4);
    check_stats("t4");
    step();

    // req3 and req0 together after rr_ptr wrapped: req0 goes first
    bus.lock_op[0] = 1'b1; bus.lock_key[0*KEY_W +: KEY_W] = 32'd1;
    bus.lock_op[3] = 1'b1; bus.lock_key[3*KEY_W +: KEY_W] = 32'd4;
    bus.lock_req = 4'b1001;
    t[0] = 0; t[3] = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      step();
      for (int r = 0; r < NUM_REQ; r++) begin
        if (bus.lock_ack[r] && t[r] == 0) begin
          t[r] = cyc;
          bus.lock_req[r] = 1'b0;
        end
      end
      if (bus.lock_req == 0) break;
    end
    bus.lock_req = '0;
    check("t4_wrap_t0", t[0], 2);
    check("t4_wrap_t3", t[3], 6);
    step();
    check("t4_wrap_cnt", locked_count, 2);
    step();

    // Full table handling from a fresh reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_grants = 0; exp_conf = 0;
    check("t5_rst_cnt", locked_count, 0);
    step();
    for (int k = 1; k <= 8; k++) do_op(0, 1'b0, 32'(k), 1'b1, k, "t5_fill");
    do_op(1, 1'b0, 32'd9, 1'b0, 8, "t5_lock9_full");
    do_op(0, 1'b1, 32'd5, 1'b1, 7, "t5_unlock5");
    do_op(2, 1'b0, 32'd9, 1'b1, 8, "t5_lock9");
    check("t5_ent4_key", dut.ent_key[4], 32'd9);
    check("t5_ent4_vld", dut.ent_vld[4], 1'b1);
    check("t5_ent4_own", dut.ent_owner[4], 2);

    // Reset while an op is in LOOKUP
    bus.lock_op[3] = 1'b0;
    bus.lock_key[3*KEY_W +: KEY_W] = 32'h77;
    bus.lock_req[3] = 1'b1;
    step();
    reset = 1'b1;
    step();
    check("t6_ack", bus.lock_ack, 0);
    check("t6_nack", bus.lock_nack, 0);
    check("t6_cnt", locked_count, 0);
    check("t6_full", table_full, 0);
    reset = 1'b0;
    bus.lock_req[3] = 1'b0;
    exp_grants = 0; exp_conf = 0;
    step();
    check("t6_quiet", {bus.lock_ack, bus.lock_nack}, 8'h00);
    do_op(1, 1'b0, 32'd1, 1'b1, 1, "t6_relock");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
